// File: rtl/handshake_constant_repeat.sv
// handshake_constant_repeat
// Emits a burst of REPEAT tokens carrying the constant VALUE for every
// accepted control token. outs_valid comes straight from a flop, so there
// is no combinational path from ctrl_valid to outs_valid. When the last
// token of a burst is accepted in the same cycle as a new control token,
// the next burst starts without a bubble.

module handshake_constant_repeat #(
  parameter int                    DATA_WIDTH = 22,
  parameter logic [DATA_WIDTH-1:0] VALUE      = DATA_WIDTH'(22'h1C9A2D),
  parameter int                    REPEAT     = 1,
  localparam int                   CNT_W      = $clog2(REPEAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last
);

  // A burst length of zero has no meaning; refuse to elaborate it.
  if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
    $error("handshake_constant_repeat: REPEAT must be in 1..65535");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             next_valid;
  logic             acc_out;
  logic             last;

  assign acc_out   = outs_valid & outs_ready;
  assign last      = (cnt == CNT_W'(REPEAT - 1));
  assign outs_last = outs_valid & last;

  // The data bus never changes, not even in reset.
  assign outs = VALUE;

  // Next-state, counter and ctrl_ready decode; ctrl_ready never looks at ctrl_valid.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned and no latch
    // is inferred.
    next_state = state;
    next_cnt   = cnt;
    next_valid = outs_valid;
    ctrl_ready = 1'b0;

    case (state)
      IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) begin
          next_state = EMIT;
          next_cnt   = '0;
          next_valid = 1'b1;
        end
      end

      EMIT: begin
        if (acc_out) begin
          if (!last) begin
            next_cnt = cnt + CNT_W'(1);
          end else begin
            // The final handshake frees the block to take the next ctrl
            // token in the same cycle, which chains bursts back to back.
            ctrl_ready = 1'b1;
            next_cnt   = '0;
            if (!ctrl_valid) begin
              next_state = IDLE;
              next_valid = 1'b0;
            end
          end
        end
      end

      default: begin
        next_state = IDLE;
        next_cnt   = '0;
        next_valid = 1'b0;
      end
    endcase

    // No control token may be taken while reset is applied.
    if (rst) begin
      ctrl_ready = 1'b0;
    end
  end

  // State, burst counter and registered output valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      outs_valid <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      outs_valid <= next_valid;
    end
  end

endmodule
